// File: rtl/mig_test_seq.sv
// mig_test_seq: self-checking DDR3 traffic sequencer on the MIG user (app_*) side.
// After calibration, writes NUM_BURSTS deterministic bursts, reads them back in
// order, compares every returned beat, then raises test_stop/test_pass.
//
// Ports
//   clk_core, reset_n          clock, async active-low reset (sync release upstream)
//   init_calib_complete        MIG calibration done; only looked at before the test starts
//   app_addr/cmd/en, app_rdy   command channel (cmd 000 write, 001 read)
//   app_wdf_*                  write data channel; mask tied 0, end == wren
//   app_rd_data(_valid)        in-order read return
//   test_stop/test_pass        sticky finish flag and pass flag (pass valid with stop)
//   err_count, first_err_addr  saturating mismatch count, address of first bad burst
module mig_test_seq #(
  parameter int unsigned                ADDR_WIDTH = 28,
  parameter int unsigned                DATA_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR  = '0,
  parameter int unsigned                NUM_BURSTS = 256,
  parameter int unsigned                ADDR_STEP  = 8
) (
  input  logic                      clk_core,
  input  logic                      reset_n,
  input  logic                      init_calib_complete,
  output logic [ADDR_WIDTH-1:0]     app_addr,
  output logic [2:0]                app_cmd,
  output logic                      app_en,
  input  logic                      app_rdy,
  output logic [DATA_WIDTH-1:0]     app_wdf_data,
  output logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  input  logic                      app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]     app_rd_data,
  input  logic                      app_rd_data_valid,
  output logic                      test_stop,
  output logic                      test_pass,
  output logic [15:0]               err_count,
  output logic [ADDR_WIDTH-1:0]     first_err_addr
);

  localparam int WPB = DATA_WIDTH / 32;
  // Counters must hold the value NUM_BURSTS and the constant 2 used for the data lead.
  localparam int CW  = (NUM_BURSTS < 3) ? 2 : $clog2(NUM_BURSTS + 1);
  localparam logic [CW-1:0] N_C    = CW'(NUM_BURSTS);
  localparam logic [CW-1:0] LAST_C = CW'(NUM_BURSTS - 1);

  typedef enum logic [1:0] {S_WAIT_CAL, S_WRITE, S_READ, S_DONE} state_t;

  state_t                  state_q;
  logic [CW-1:0]           w_q, c_q, r_q, v_q;
  logic [15:0]             err_q;
  logic [ADDR_WIDTH-1:0]   ferr_q;
  logic                    stop_q, pass_q;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [CW-1:0] i);
    logic [DATA_WIDTH-1:0] d;
    logic [31:0]           base;
    d    = '0;
    base = 32'(i) * 32'(WPB);
    for (int k = 0; k < WPB; k++)
      d[k*32 +: 32] = (base + 32'(k)) ^ 32'h5A5A_5A5A;
    return d;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [CW-1:0] i);
    return BASE_ADDR + ADDR_WIDTH'(i) * ADDR_WIDTH'(ADDR_STEP);
  endfunction

  logic                    wr_ph, rd_ph;
  logic                    wdf_vld, cmd_vld_w, cmd_vld_r;
  logic                    w_acc, c_acc, r_acc, beat, mism;
  logic [CW-1:0]           lead;
  logic [DATA_WIDTH-1:0]   exp_rd;
  logic [15:0]             err_d;

  // Everything driven toward the MIG is decoded from registered state only,
  // so valid never depends combinationally on the same cycle's rdy.
  always_comb begin
    wr_ph     = (state_q == S_WRITE);
    rd_ph     = (state_q == S_READ);
    lead      = w_q - c_q;
    // Data may run ahead of its command by at most two bursts.
    wdf_vld   = wr_ph && (w_q < N_C) && (lead < CW'(2));
    // A write command is only issued once its data has already been accepted.
    cmd_vld_w = wr_ph && (c_q < N_C) && (c_q < w_q);
    cmd_vld_r = rd_ph && (r_q < N_C);
    w_acc     = wdf_vld & app_wdf_rdy;
    c_acc     = cmd_vld_w & app_rdy;
    r_acc     = cmd_vld_r & app_rdy;
    // Beats with no outstanding read (v >= r) are stray and ignored.
    beat      = rd_ph && app_rd_data_valid && (v_q < r_q);
    exp_rd    = pattern(v_q);
    mism      = beat && (app_rd_data != exp_rd);
    err_d     = (mism && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
  end

  assign app_en         = cmd_vld_w | cmd_vld_r;
  assign app_cmd        = rd_ph ? 3'b001 : 3'b000;
  assign app_addr       = wr_ph ? addr_of(c_q) : (rd_ph ? addr_of(r_q) : '0);
  assign app_wdf_wren   = wdf_vld;
  assign app_wdf_end    = wdf_vld;
  assign app_wdf_data   = wr_ph ? pattern(w_q) : '0;
  assign app_wdf_mask   = '0;
  assign test_stop      = stop_q;
  assign test_pass      = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT_CAL;
      w_q     <= '0;
      c_q     <= '0;
      r_q     <= '0;
      v_q     <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      stop_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT_CAL: if (init_calib_complete) state_q <= S_WRITE;
        S_WRITE: begin
          if (w_acc) w_q <= w_q + CW'(1);
          if (c_acc) begin
            c_q <= c_q + CW'(1);
            if (c_q == LAST_C) state_q <= S_READ;
          end
        end
        S_READ: begin
          if (r_acc) r_q <= r_q + CW'(1);
          if (beat) begin
            v_q   <= v_q + CW'(1);
            err_q <= err_d;
            if (mism && (err_q == 16'd0)) ferr_q <= addr_of(v_q);
            if (v_q == LAST_C) begin
              state_q <= S_DONE;
              stop_q  <= 1'b1;
              // Uses the post-update count so a bad final beat still fails the test.
              pass_q  <= (err_d == 16'd0);
            end
          end
        end
        default: stop_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mig_test_seq.sv
// Bench for mig_test_seq: a behavioural MIG model (random backpressure, in-order
// read return from a sparse memory, optional bit flips) plus directed phases.
module tb_mig_test_seq;
  localparam int AW = 28, DW = 128, N = 8, STEP = 8;
  localparam logic [AW-1:0] BASE = '0;

  logic            clk, reset_n, calib;
  logic [AW-1:0]   app_addr;
  logic [2:0]      app_cmd;
  logic            app_en, app_rdy;
  logic [DW-1:0]   app_wdf_data;
  logic [DW/8-1:0] app_wdf_mask;
  logic            app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DW-1:0]   app_rd_data;
  logic            app_rd_data_valid;
  logic            test_stop, test_pass;
  logic [15:0]     err_count;
  logic [AW-1:0]   first_err_addr;

  mig_test_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
                 .NUM_BURSTS(N), .ADDR_STEP(STEP)) dut (
    .clk_core(clk), .reset_n(reset_n), .init_calib_complete(calib),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .test_stop(test_stop), .test_pass(test_pass), .err_count(err_count),
    .first_err_addr(first_err_addr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rules: data word k of burst i and the burst address.
  function automatic logic [DW-1:0] exp_pat(input int i);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < DW/32; k++) d[32*k +: 32] = 32'(i*(DW/32) + k) ^ 32'h5A5A_5A5A;
    return d;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int i);
    longint unsigned a;
    a = longint'(BASE) + longint'(i) * STEP;
    return a[AW-1:0];
  endfunction

  // Controls written only by the stimulus block.
  logic          bp_en, lat_rand, expect_idle;
  int            lat, spur_cnt;
  logic [N-1:0]  fault_map;

  // MIG model state, written only by the model block.
  typedef struct { int due; logic bad; logic [AW-1:0] addr; logic [DW-1:0] data; } rd_t;
  rd_t           rq[$];
  rd_t           rd;
  logic [DW-1:0] wq[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] wr_log [N];
  int            cyc = 0, nw, nc, nr, nb, m_err, last_due, last_beat_cyc, spur_done = 0;
  logic [AW-1:0] m_first, prev_addr;
  logic [2:0]    prev_cmd;
  logic [DW-1:0] prev_data;
  logic          prev_en, prev_w;

  always @(negedge clk) begin
    if (!reset_n) begin
      nw = 0; nc = 0; nr = 0; nb = 0; m_err = 0; m_first = '0;
      last_due = 0; last_beat_cyc = -10; prev_en = 0; prev_w = 0;
      wq.delete(); rq.delete(); mem.delete();
      app_rd_data_valid = 1'b0; app_rd_data = '0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    end else begin
      cyc++;
      check("err_count", err_count, m_err);
      check("first_err_addr", first_err_addr, m_first);
      check("wdf_end", app_wdf_end, app_wdf_wren);
      check("wdf_mask", app_wdf_mask, '0);
      if (expect_idle) begin
        check("idle_en", app_en, 0);
        check("idle_wren", app_wdf_wren, 0);
      end
      if (prev_en) begin
        check("en_hold", app_en, 1);
        check("addr_hold", app_addr, prev_addr);
        check("cmd_hold", app_cmd, prev_cmd);
      end
      if (prev_w) begin
        check("wren_hold", app_wdf_wren, 1);
        check("data_hold", app_wdf_data, prev_data);
      end
      if (cyc == last_beat_cyc + 1) begin
        check("stop_at_done", test_stop, 1);
        check("pass_at_done", test_pass, m_err == 0);
      end
      app_rdy     = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      app_wdf_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (app_en && app_rdy) begin
        if (app_cmd == 3'b000) begin
          check("wr_cmd_count", nc < N, 1);
          check("wr_addr", app_addr, exp_addr(nc));
          check("cmd_after_data", wq.size() > 0, 1);
          mem[app_addr] = (wq.size() > 0) ? wq.pop_front() : '0;
          nc++;
        end else begin
          check("rd_cmd", app_cmd, 3'b001);
          check("rd_cmd_count", nr < N, 1);
          check("rd_addr", app_addr, exp_addr(nr));
          check("rd_after_wr", nc, N);
          rd.addr = app_addr;
          rd.data = mem.exists(app_addr) ? mem[app_addr] : '0;
          rd.bad  = (nr < N) ? fault_map[nr] : 1'b0;
          if (rd.bad) rd.data[0] = ~rd.data[0];
          rd.due  = cyc + (lat_rand ? int'($urandom_range(1, 25)) : lat);
          if (rd.due <= last_due) rd.due = last_due + 1;
          last_due = rd.due;
          rq.push_back(rd);
          nr++;
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        check("wr_data_count", nw < N, 1);
        check("wr_data", app_wdf_data, exp_pat(nw));
        wq.push_back(app_wdf_data);
        if (nw < N) wr_log[nw] = app_wdf_data;
        nw++;
        check("lead_le2", (nw - nc) <= 2, 1);
      end
      prev_en = app_en && !app_rdy;       prev_addr = app_addr; prev_cmd = app_cmd;
      prev_w  = app_wdf_wren && !app_wdf_rdy; prev_data = app_wdf_data;
      app_rd_data_valid = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        rd = rq.pop_front();
        app_rd_data_valid = 1'b1;
        app_rd_data = rd.data;
        if (rd.bad) begin
          if (m_err == 0) m_first = rd.addr;
          m_err++;
        end
        if (nb == N - 1) begin
          check("stop_before_done", test_stop, 0);
          last_beat_cyc = cyc;
        end
        nb++;
      end else if (spur_cnt != spur_done) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = {$urandom, $urandom, $urandom, $urandom};
        spur_done++;
      end
    end
  end

  task automatic run_to_stop(input string tag);
    int t = 0;
    while (!test_stop && t < 5000) begin @(negedge clk); t++; end
    check({tag, "_timeout"}, test_stop, 1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; calib = 1'b0; expect_idle = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_model(input string tag, input int which, input int target);
    int t = 0;
    while (((which == 0) ? nc : nr) < target && t < 2000) begin @(negedge clk); t++; end
    check({tag, "_wait"}, ((which == 0) ? nc : nr) >= target, 1);
  endtask

  initial begin
    reset_n = 1'b0; calib = 1'b0; bp_en = 1'b0; lat_rand = 1'b0; lat = 20;
    fault_map = '0; expect_idle = 1'b1; spur_cnt = 0;
    @(negedge clk);
    check("rst_en", app_en, 0);          check("rst_wren", app_wdf_wren, 0);
    check("rst_cmd", app_cmd, 0);        check("rst_addr", app_addr, 0);
    check("rst_stop", test_stop, 0);     check("rst_pass", test_pass, 0);
    check("rst_err", err_count, 0);      check("rst_ferr", first_err_addr, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Phase 1: ideal MIG, fixed read latency 20.
    repeat (10) @(negedge clk);
    calib = 1'b1; expect_idle = 1'b0;
    run_to_stop("p1");
    check("p1_burst1", wr_log[1], 128'h5A5A5A5D_5A5A5A5C_5A5A5A5F_5A5A5A5E);
    check("p1_pass", test_pass, 1);      check("p1_err", err_count, 0);
    check("p1_writes", nc, N);           check("p1_reads", nr, N);
    check("p1_beats", nb, N);
    repeat (5) @(negedge clk);
    check("p1_sticky", test_stop, 1);    check("p1_done_en", app_en, 0);
    check("p1_done_wren", app_wdf_wren, 0);

    // Phase 2: random backpressure and latency, calib dropped mid-WRITE, stray beat.
    do_reset();
    bp_en = 1'b1; lat_rand = 1'b1;
    repeat (5) @(negedge clk);
    calib = 1'b1; expect_idle = 1'b0;
    wait_model("p2_first_wr", 0, 1);
    calib = 1'b0;
    spur_cnt++;
    run_to_stop("p2");
    check("p2_pass", test_pass, 1);      check("p2_err", err_count, 0);
    check("p2_beats", nb, N);            check("p2_spur_sent", spur_done, spur_cnt);

    // Phase 3: flipped bit 0 in bursts 3 and 5.
    do_reset();
    bp_en = 1'b0; lat_rand = 1'b0; lat = 7; fault_map = N'(8'b0010_1000);
    calib = 1'b1; expect_idle = 1'b0;
    run_to_stop("p3");
    check("p3_stop", test_stop, 1);      check("p3_pass", test_pass, 0);
    check("p3_err", err_count, 2);       check("p3_ferr", first_err_addr, 28'd24);

    // Phase 4: long calibration, async reset mid-READ, then a clean rerun.
    do_reset();
    fault_map = '0; bp_en = 1'b1; lat_rand = 1'b1;
    repeat (1000) @(negedge clk);
    calib = 1'b1; expect_idle = 1'b0;
    wait_model("p4_rd", 1, 2);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("ar_en", app_en, 0);           check("ar_wren", app_wdf_wren, 0);
    check("ar_addr", app_addr, 0);       check("ar_cmd", app_cmd, 0);
    check("ar_stop", test_stop, 0);      check("ar_pass", test_pass, 0);
    check("ar_err", err_count, 0);       check("ar_ferr", first_err_addr, 0);
    calib = 1'b0; expect_idle = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    bp_en = 1'b0;
    calib = 1'b1; expect_idle = 1'b0;
    run_to_stop("p4");
    check("p4_pass", test_pass, 1);      check("p4_err", err_count, 0);
    check("p4_beats", nb, N);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
